// File: rtl/binary_window_builder_pkg.sv
// Shared window definitions for the binary window builder and the median stage it feeds.
// Latency: n/a (constants, types and a helper function only).
// Backpressure: n/a.
package binary_window_builder_pkg;

    // Geometry of the 3x3 binary neighbourhood.
    localparam int WIN_ROWS     = 3;
    localparam int WIN_COLS     = 3;
    localparam int WIN_BITS     = WIN_ROWS * WIN_COLS;

    typedef logic [WIN_BITS-1:0] window_t;

    // Bit index of the tap that is row_back lines and col_back pixels behind
    // the newest accepted pixel.
    function automatic int tap_index(input int row_back, input int col_back);
        return row_back * WIN_COLS + col_back;
    endfunction

    // Named taps: R<lines back>_C<pixels back>. R0_C0 is the newest pixel.
    localparam int TAP_R0_C0 = tap_index(0, 0);
    localparam int TAP_R0_C1 = tap_index(0, 1);
    localparam int TAP_R0_C2 = tap_index(0, 2);
    localparam int TAP_R1_C0 = tap_index(1, 0);
    localparam int TAP_R1_C1 = tap_index(1, 1);
    localparam int TAP_R1_C2 = tap_index(1, 2);
    localparam int TAP_R2_C0 = tap_index(2, 0);
    localparam int TAP_R2_C1 = tap_index(2, 1);
    localparam int TAP_R2_C2 = tap_index(2, 2);

    // Centre of the neighbourhood, the pixel the median result replaces.
    localparam int WIN_CENTER = TAP_R1_C1;

endpackage

// File: rtl/binary_window_builder_bit_line_delay.sv
// DEPTH-stage 1-bit shift register used as a single image line buffer.
// Latency: dout is the bit written DEPTH enabled cycles earlier (zero after reset).
// Backpressure: none; en low freezes the contents.
module bit_line_delay #(
    parameter int DEPTH = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] sr;

    generate
        if (DEPTH == 1) begin : g_single
            // Single stage: a plain enabled flop.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sr <= '0;
                end else if (en) begin
                    sr <= din;
                end
            end
        end else begin : g_chain
            // Shift towards the MSB; the MSB is the oldest stored bit.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sr <= '0;
                end else if (en) begin
                    sr <= {sr[DEPTH-2:0], din};
                end
            end
        end
    endgenerate

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/binary_window_builder.sv
// Builds registered 3x3 windows from a raster 1-bit pixel stream, flagging in-image windows.
// Latency: window, windowValid and frameDone for a pixel appear one edge after it is accepted.
// Backpressure: none; pixelValid gaps simply freeze all shifting and counting.
module binary_window_builder
    import binary_window_builder_pkg::*;
#(
    parameter int IMG_WIDTH  = 16,
    parameter int IMG_HEIGHT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pixelIn,
    input  logic                pixelValid,
    input  logic                sof,
    output logic [WIN_BITS-1:0] windowOut,
    output logic                windowValid,
    output logic                frameDone
);

    localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    // Wrap points compare against the real dimension, not a power-of-two overflow.
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_FIRST_FULL = COL_W'(WIN_COLS - 1);
    localparam logic [ROW_W-1:0] ROW_FIRST_FULL = ROW_W'(WIN_ROWS - 1);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col_cur;
    logic [ROW_W-1:0] row_cur;
    logic [COL_W-1:0] col_nxt;
    logic [ROW_W-1:0] row_nxt;
    logic             col_last_hit;
    logic             row_last_hit;
    logic             in_window;

    logic             tap_r1;
    logic             tap_r2;
    window_t          win;

    // Position of the pixel on the input this cycle; sof forces it to (0,0).
    always_comb begin
        col_cur      = col;
        row_cur      = row;
        if (sof) begin
            col_cur = '0;
            row_cur = '0;
        end
        col_last_hit = (col_cur == COL_LAST);
        row_last_hit = (row_cur == ROW_LAST);
        in_window    = (row_cur >= ROW_FIRST_FULL) && (col_cur >= COL_FIRST_FULL);
        col_nxt      = col_cur + COL_W'(1);
        row_nxt      = row_cur;
        if (col_last_hit) begin
            col_nxt = '0;
            row_nxt = row_last_hit ? '0 : row_cur + ROW_W'(1);
        end
    end

    // Position counters: advance per accepted pixel, or just restart on an idle sof.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (pixelValid) begin
            col <= col_nxt;
            row <= row_nxt;
        end else if (sof) begin
            col <= '0;
            row <= '0;
        end
    end

    // Two chained line buffers supply the pixels one and two lines above.
    bit_line_delay #(
        .DEPTH (IMG_WIDTH)
    ) u_line0 (
        .clk   (clk),
        .reset (reset),
        .en    (pixelValid),
        .din   (pixelIn),
        .dout  (tap_r1)
    );

    bit_line_delay #(
        .DEPTH (IMG_WIDTH)
    ) u_line1 (
        .clk   (clk),
        .reset (reset),
        .en    (pixelValid),
        .din   (tap_r1),
        .dout  (tap_r2)
    );

    // Each row tap shifts into its 3-bit window row; older columns move to higher bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win <= '0;
        end else if (pixelValid) begin
            win[TAP_R0_C0] <= pixelIn;
            win[TAP_R0_C1] <= win[TAP_R0_C0];
            win[TAP_R0_C2] <= win[TAP_R0_C1];
            win[TAP_R1_C0] <= tap_r1;
            win[TAP_R1_C1] <= win[TAP_R1_C0];
            win[TAP_R1_C2] <= win[TAP_R1_C1];
            win[TAP_R2_C0] <= tap_r2;
            win[TAP_R2_C1] <= win[TAP_R2_C0];
            win[TAP_R2_C2] <= win[TAP_R2_C1];
        end
    end

    // Status pulses are registered alongside the window so they line up with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            windowValid <= 1'b0;
            frameDone   <= 1'b0;
        end else begin
            windowValid <= pixelValid && in_window;
            frameDone   <= pixelValid && col_last_hit && row_last_hit;
        end
    end

    assign windowOut = win;

endmodule

// File: tb/tb_binary_window_builder.sv
module tb_binary_window_builder;

    localparam int W = 4;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       pixelIn;
    logic       pixelValid;
    logic       sof;
    logic [8:0] windowOut;
    logic       windowValid;
    logic       frameDone;

    always #5 clk = ~clk;

    binary_window_builder #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pixelIn     (pixelIn),
        .pixelValid  (pixelValid),
        .sof         (sof),
        .windowOut   (windowOut),
        .windowValid (windowValid),
        .frameDone   (frameDone)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: full history of accepted pixels since reset, plus the
    // current frame as a 2-D image addressed by (row, col).
    bit         hist[$];
    bit         frame[H][W];
    int         mr = 0;
    int         mc = 0;

    // Per-scenario observations.
    int         nv;
    int         acc;
    logic [8:0] vwins[$];
    int         fd_at[$];

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs == exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Window as a pure function of pixel history: tap (j,d) is the pixel accepted
    // j*W + d pixels before the newest one, zero if none has been accepted yet.
    function automatic logic [8:0] hist_win();
        logic [8:0] w;
        int         idx;
        w = '0;
        for (int j = 0; j < 3; j++) begin
            for (int d = 0; d < 3; d++) begin
                idx = hist.size() - 1 - j * W - d;
                if (idx >= 0) w[j*3+d] = hist[idx];
            end
        end
        return w;
    endfunction

    task automatic start_scn();
        nv  = 0;
        acc = 0;
        vwins.delete();
        fd_at.delete();
    endtask

    task automatic model_reset();
        hist.delete();
        mr = 0;
        mc = 0;
    endtask

    // One clock: drive inputs, advance the model, then check outputs after the edge.
    task automatic cycle(input bit pv, input bit pix, input bit sf);
        logic       ev;
        logic       efd;
        logic [8:0] fw;
        int         r;
        int         c;
        pixelValid = pv;
        pixelIn    = pix;
        sof        = sf;
        ev  = 1'b0;
        efd = 1'b0;
        fw  = '0;
        if (sf) begin
            mr = 0;
            mc = 0;
        end
        if (pv) begin
            r = mr;
            c = mc;
            acc++;
            hist.push_back(pix);
            frame[r][c] = pix;
            ev  = (r >= 2) && (c >= 2);
            efd = (r == H - 1) && (c == W - 1);
            if (ev) begin
                for (int j = 0; j < 3; j++)
                    for (int d = 0; d < 3; d++)
                        fw[j*3+d] = frame[r-j][c-d];
            end
            if (mc == W - 1) begin
                mc = 0;
                mr = (mr == H - 1) ? 0 : mr + 1;
            end else begin
                mc++;
            end
        end
        @(posedge clk);
        #1;
        chk("windowValid", {8'h00, windowValid}, {8'h00, ev});
        chk("frameDone", {8'h00, frameDone}, {8'h00, efd});
        chk("windowOut_history", windowOut, hist_win());
        if (ev) chk("windowOut_image", windowOut, fw);
        if (windowValid) begin
            nv++;
            vwins.push_back(windowOut);
        end
        if (frameDone) fd_at.push_back(acc);
        pixelValid = 1'b0;
        sof        = 1'b0;
    endtask

    task automatic chk_single_one(input string tag);
        logic [8:0] exp_w[4];
        exp_w[0] = 9'h010;
        exp_w[1] = 9'h020;
        exp_w[2] = 9'h080;
        exp_w[3] = 9'h100;
        chk_int({tag, "_count"}, vwins.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < vwins.size()) chk({tag, "_win"}, vwins[i], exp_w[i]);
        chk_int({tag, "_fd_count"}, fd_at.size(), 1);
        if (fd_at.size() > 0) chk_int({tag, "_fd_pos"}, fd_at[0], 16);
    endtask

    task automatic chk_all_ones(input string tag);
        chk_int({tag, "_count"}, nv, 4);
        foreach (vwins[i]) chk({tag, "_win"}, vwins[i], 9'h1FF);
        chk_int({tag, "_fd_count"}, fd_at.size(), 1);
        if (fd_at.size() > 0) chk_int({tag, "_fd_pos"}, fd_at[0], 16);
    endtask

    initial begin
        reset      = 1'b1;
        pixelIn    = 1'b0;
        pixelValid = 1'b0;
        sof        = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_windowOut", windowOut, 9'h000);
        chk("reset_windowValid", {8'h00, windowValid}, 9'h000);
        chk("reset_frameDone", {8'h00, frameDone}, 9'h000);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // All ones with sof on the first pixel.
        start_scn();
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b1, i == 0);
        chk_all_ones("all_ones");

        // Single one at (1,1).
        start_scn();
        for (int i = 0; i < 16; i++) cycle(1'b1, i == 5, i == 0);
        chk_single_one("single_one");

        // Same frame with an idle cycle (random junk on pixelIn) after every pixel.
        start_scn();
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, i == 5, i == 0);
            cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        end
        chk_single_one("gapped");

        // Two back-to-back frames of random pixels, sof only on the very first.
        start_scn();
        for (int i = 0; i < 32; i++) cycle(1'b1, 1'($urandom_range(0, 1)), i == 0);
        chk_int("b2b_count", nv, 8);
        chk_int("b2b_fd_count", fd_at.size(), 2);
        if (fd_at.size() == 2) begin
            chk_int("b2b_fd_first", fd_at[0], 16);
            chk_int("b2b_fd_second", fd_at[1], 32);
        end

        // sof at the sixth pixel abandons the partial frame.
        start_scn();
        for (int i = 0; i < 21; i++) cycle(1'b1, 1'($urandom_range(0, 1)), (i == 0) || (i == 5));
        chk_int("sof_mid_count", nv, 4);
        chk_int("sof_mid_fd_count", fd_at.size(), 1);
        if (fd_at.size() > 0) chk_int("sof_mid_fd_pos", fd_at[0], 21);

        // sof on an idle cycle: the next accepted pixel is (0,0).
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        start_scn();
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b1, 1'b0);
        chk_all_ones("idle_sof");

        // Reset asserted between edges mid-frame.
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b1, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        chk("async_rst_windowOut", windowOut, 9'h000);
        chk("async_rst_windowValid", {8'h00, windowValid}, 9'h000);
        chk("async_rst_frameDone", {8'h00, frameDone}, 9'h000);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        start_scn();
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b1, 1'b0);
        chk_all_ones("after_reset");

        // Random pixels, random gaps and occasional sof, checked cycle by cycle.
        start_scn();
        for (int i = 0; i < 300; i++)
            cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 39) == 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/binary_window_builder.md
# binary_window_builder

Converts a raster-ordered serial stream of 1-bit pixels into 3x3 neighbourhood windows, one per accepted pixel once the window lies fully inside the image. It sits directly upstream of the binary median filter and drives that stage's 9-bit window input. It buffers two previous image lines internally and tracks row/column position. It flags which outputs are valid windows.

## Interface
Parameters:
- IMG_WIDTH, 16, pixels per line; legal range 3..1024.
- IMG_HEIGHT, 16, lines per frame; legal range 3..1024.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- pixelIn  input  1  current binary pixel.
- pixelValid  input  1  pixelIn is accepted this cycle; no backpressure.
- sof  input  1  start of frame; restarts position counters.
- windowOut  output  9  3x3 window, registered.
- windowValid  output  1  one-cycle pulse; windowOut is a complete in-image window.
- frameDone  output  1  one-cycle pulse after the last pixel of a frame is accepted.

## Operation
- Window bit map, with (r,c) being the position of the accepted pixel:
  - windowOut[0]=(r,c), [1]=(r,c-1), [2]=(r,c-2).
  - [3..5] hold the same three columns for row r-1.
  - [6..8] hold the same three columns for row r-2.
  - Centre pixel (r-1,c-1) is bit 4.
- Per accepted pixel:
  - Line buffer 0 (IMG_WIDTH deep) delays pixelIn by one line.
  - Line buffer 1 delays line-0 output by a further line.
  - Each of the three row taps shifts into its 3-bit window row register.
- Position counters:
  - col runs 0..IMG_WIDTH-1, then wraps to 0 and increments row.
  - row runs 0..IMG_HEIGHT-1, then wraps to 0 (free-running frames when sof is not used).
- windowValid is asserted for an accepted pixel with row>=2 and col>=2. This gives (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame.
- No edge padding. Windows straddling the line wrap are never flagged valid.
- frameDone is asserted for the accepted pixel at (IMG_HEIGHT-1, IMG_WIDTH-1).
- pixelValid low: nothing shifts, counters hold, windowValid and frameDone are 0, windowOut holds its last value.
- sof handling:
  - sof with pixelValid=1: that pixel is taken as (0,0).
  - sof with pixelValid=0: counters go to (0,0) and the next accepted pixel is (0,0).
  - Line-buffer contents are not cleared by sof; they are masked by the row/col gating.
- sof mid-frame: the partial frame is abandoned. No frameDone is issued for it.

## Timing
- Reset values:
  - windowOut=9'h000, windowValid=0, frameDone=0.
  - Counters at (0,0); line buffers and window registers cleared.
- Reset takes effect asynchronously and is released synchronously to clk.
- Latency: an accepted pixel at edge N appears in windowOut[0] after edge N, together with windowValid and frameDone for that pixel.
- Throughput: one pixel per cycle sustained. Arbitrary gaps in pixelValid are tolerated.
- Reset mid-frame: all state is lost, and the next accepted pixel is (0,0).
- Counter widths are $clog2 of the parameter, with a minimum of 1 bit. The wrap compare is against the parameter minus 1, never a power-of-two overflow.

## Structure
- Shared package holds:
  - WIN_BITS=9 and WIN_CENTER=4.
  - Named bit-index constants for the nine window taps, so the median filter and this block agree on the bit map.
- One sub-module: bit_line_delay, a parameterised DEPTH-stage 1-bit shift register with enable and async active-high reset. It is instantiated twice with DEPTH=IMG_WIDTH.
- Counters, window registers and output registers live in the top.

## Test plan
All scenarios use IMG_WIDTH=4 and IMG_HEIGHT=4.
- **All ones:** 16 consecutive pixels of 1 with sof on the first -> exactly 4 windowValid pulses, each with windowOut=9'h1FF, and frameDone on the 16th pixel.
- **Single one:** pixel (1,1)=1, all others 0:
  - windows at (2,2), (2,3), (3,2), (3,3) are 9'h010, 9'h020, 9'h080, 9'h100 in that order.
- **Gapped input:** same frame as the single-one case with pixelValid low on every other cycle -> identical window sequence, with pulses only on accepted cycles.
- **Back-to-back frames without sof:** 32 pixels -> 8 windowValid pulses and frameDone on the 16th and 32nd pixels. Frame 2 windows are correct, with no frame-1 leakage.
- **sof mid-frame:** sof at pixel 6 -> counters restart, next 16 pixels yield 4 valid windows, and no frameDone for the aborted frame.
- **Reset mid-frame:** reset asserted asynchronously between edges -> all outputs 0 immediately; a subsequent full frame reproduces the all-ones result.
